// File: rtl/hazard_probe.sv
// Sprite hazard detector: one sweep reads NUM_PROBES map cells around the sprite feet and flags hazard colours.
// Latency: done pulses NUM_PROBES+ROM_LATENCY+1 cycles after the cycle that accepts start.
// Backpressure: none; start is accepted only in IDLE, and a start seen while busy is dropped rather than queued.
//
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   start, x, y, height    sweep request and sprite geometry (latched when start is accepted)
//   haz_color0/1, haz_en   hazard colours and enables, sampled whenever a ROM return arrives
//   clear_dead             clears the sticky is_dead flag
//   rom_addr, rom_data     shared map-ROM read port (fixed ROM_LATENCY)
//   busy, done, hit_mask, is_dead   sweep status and results
module hazard_probe #(
    parameter int NUM_PROBES  = 3,
    parameter int PROBE_DX    = 8,
    parameter int PROBE_DY    = 4,
    parameter int SCALE_SHIFT = 2,
    parameter int MAP_COLS    = 160,
    parameter int ROM_LATENCY = 1,
    parameter int ADDR_W      = 17
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [6:0]            height,
    input  logic [23:0]           haz_color0,
    input  logic [23:0]           haz_color1,
    input  logic [1:0]            haz_en,
    input  logic                  clear_dead,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [23:0]           rom_data,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_PROBES-1:0] hit_mask,
    output logic                  is_dead
);

    // NUM_PROBES <= 15 and ROM_LATENCY <= 4 bound these widths.
    localparam int IDX_W = 4;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [9:0]                          x_q, x_d;
    logic [9:0]                          y_q, y_d;
    logic [5:0]                          hh_q, hh_d;        // height >> 1, the only part of height used
    logic [NUM_PROBES-1:0]               acc_q, acc_d;
    logic [NUM_PROBES-1:0]               hit_mask_q, hit_mask_d;
    logic                                is_dead_q, is_dead_d;
    logic                                done_q, done_d;
    logic [ROM_LATENCY-1:0]              pv_q, pv_d;        // return-tracking valid bits
    logic [ROM_LATENCY-1:0][IDX_W-1:0]   pi_q, pi_d;        // return-tracking probe indices

    // Probe geometry for the probe currently being issued.
    logic [10:0]        yb_sum;
    logic [8:0]         yb;
    logic [4:0]         k;
    logic [11:0]        off;
    logic signed [11:0] px_s, py_s;
    logic [9:0]         px_c;
    logic [8:0]         py_c;

    always_comb begin
        yb_sum = {1'b0, y_q} + {5'b0, hh_q};
        yb     = (yb_sum > 11'd479) ? 9'd479 : yb_sum[8:0];
        // Probes fan out alternately left (odd) and right (even) at growing distance k.
        k      = ({1'b0, idx_q} + 5'd1) >> 1;
        off    = 12'(k * PROBE_DX);
        if (idx_q == '0) begin
            px_s = $signed({2'b00, x_q});
            py_s = $signed({3'b000, yb});
        end else begin
            px_s = idx_q[0] ? ($signed({2'b00, x_q}) - $signed(off))
                            : ($signed({2'b00, x_q}) + $signed(off));
            py_s = $signed({3'b000, yb}) - $signed(12'(PROBE_DY));
        end
        // Saturate to the visible playfield; negative results must not wrap.
        if (px_s < 12'sd0)        px_c = '0;
        else if (px_s > 12'sd639) px_c = 10'd639;
        else                      px_c = px_s[9:0];
        if (py_s < 12'sd0)        py_c = '0;
        else if (py_s > 12'sd479) py_c = 9'd479;
        else                      py_c = py_s[8:0];
    end

    assign rom_addr = (state_q == S_ISSUE)
                    ? ADDR_W'(px_c >> SCALE_SHIFT) + ADDR_W'(py_c >> SCALE_SHIFT) * ADDR_W'(MAP_COLS)
                    : '0;

    logic ret_hit;
    assign ret_hit = pv_q[ROM_LATENCY-1] &&
                     ((haz_en[0] && (rom_data == haz_color0)) ||
                      (haz_en[1] && (rom_data == haz_color1)));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        hh_d       = hh_q;
        hit_mask_d = hit_mask_q;
        done_d     = 1'b0;
        acc_d      = acc_q;
        pv_d       = '0;
        pi_d       = '0;
        is_dead_d  = is_dead_q & ~clear_dead;

        for (int i = 0; i < NUM_PROBES; i++) begin
            if (ret_hit && (pi_q[ROM_LATENCY-1] == IDX_W'(i))) acc_d[i] = 1'b1;
        end

        pv_d[0] = (state_q == S_ISSUE);
        pi_d[0] = idx_q;
        for (int j = 1; j < ROM_LATENCY; j++) begin
            pv_d[j] = pv_q[j-1];
            pi_d[j] = pi_q[j-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    hh_d    = height[6:1];
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (idx_q == IDX_W'(NUM_PROBES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(ROM_LATENCY - 1)) begin
                    // The last return lands this cycle, so publish acc_d rather than acc_q.
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    hit_mask_d = acc_d;
                    if (|acc_d) is_dead_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // A clear arriving in the done cycle must not undo this sweep's hit.
                if (|hit_mask_q) is_dead_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hh_q       <= '0;
            acc_q      <= '0;
            hit_mask_q <= '0;
            is_dead_q  <= 1'b0;
            done_q     <= 1'b0;
            pv_q       <= '0;
            pi_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hh_q       <= hh_d;
            acc_q      <= acc_d;
            hit_mask_q <= hit_mask_d;
            is_dead_q  <= is_dead_d;
            done_q     <= done_d;
            pv_q       <= pv_d;
            pi_q       <= pi_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hit_mask = hit_mask_q;
    assign is_dead  = is_dead_q;

endmodule

// File: tb/tb_hazard_probe.sv
// Bench for hazard_probe: directed and random sweeps against a scoreboard.
// Expected addresses and done results are queued with their due cycle when start is driven.
// A negedge monitor pops and compares them as the DUT produces them.
module tb_hazard_probe;

    localparam int NP   = 3;
    localparam int LAT  = 1;
    localparam int DX   = 8;
    localparam int DY   = 4;
    localparam int SS   = 2;
    localparam int COLS = 160;
    localparam int AW   = 17;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic [9:0]    x = '0, y = '0;
    logic [6:0]    height = '0;
    logic [23:0]   haz_color0 = '0, haz_color1 = '0;
    logic [1:0]    haz_en = '0;
    logic          clear_dead = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data;
    logic          busy, done, is_dead;
    logic [NP-1:0] hit_mask;

    hazard_probe #(
        .NUM_PROBES(NP), .PROBE_DX(DX), .PROBE_DY(DY), .SCALE_SHIFT(SS),
        .MAP_COLS(COLS), .ROM_LATENCY(LAT), .ADDR_W(AW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .x(x), .y(y), .height(height),
        .haz_color0(haz_color0), .haz_color1(haz_color1), .haz_en(haz_en),
        .clear_dead(clear_dead), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .done(done), .hit_mask(hit_mask), .is_dead(is_dead)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Map ROM: background black, two programmable coloured cells.
    int hot_a0 = -1, hot_a1 = -1;
    logic [23:0] hot_c0 = '0, hot_c1 = '0;

    function automatic logic [23:0] lookup(input int a);
        if (a == hot_a0) return hot_c0;
        if (a == hot_a1) return hot_c1;
        return 24'h000000;
    endfunction

    logic [23:0] rom_pipe [LAT];
    always @(posedge Clk) begin
        rom_pipe[0] <= lookup(int'(rom_addr));
        for (int j = 1; j < LAT; j++) rom_pipe[j] <= rom_pipe[j-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference geometry, written directly from the probe layout rules.
    function automatic int model_addr(input int sx, input int sy, input int sh, input int i);
        int yb, px, py, k;
        yb = sy + sh / 2;
        if (yb > 479) yb = 479;
        if (i == 0) begin
            px = sx;
            py = yb;
        end else begin
            k  = (i + 1) / 2;
            px = (i % 2 == 1) ? sx - k * DX : sx + k * DX;
            py = yb - DY;
        end
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
        return ((px >> SS) + (py >> SS) * COLS) & ((1 << AW) - 1);
    endfunction

    typedef struct { int cyc; int a; int b; } ent_t;
    ent_t aq[$];   // a = probe index, b = address
    ent_t dq[$];   // a = hit mask, b = is_dead
    int   b_from = 1, b_to = 0;
    bit   mon_en = 1'b0;
    int   model_dead = 0;

    always @(negedge Clk) begin
        if (mon_en) begin
            while (aq.size() > 0 && aq[0].cyc <= cyc) begin
                ent_t e;
                e = aq.pop_front();
                check_val($sformatf("rom_addr_p%0d", e.a), 32'(rom_addr), e.b);
            end
            check_val("busy", 32'(busy), (cyc >= b_from && cyc <= b_to) ? 1 : 0);
            if (done) begin
                if (dq.size() == 0) begin
                    check_val("unexpected_done", 32'(done), 0);
                end else begin
                    ent_t e;
                    e = dq.pop_front();
                    check_val("done_cycle", cyc, e.cyc);
                    check_val("hit_mask", 32'(hit_mask), e.a);
                    check_val("is_dead", 32'(is_dead), e.b);
                end
            end
        end
    end

    // One sweep, entered #1 after a posedge. Optional extra start, reset, and clear pair at offsets t.
    task automatic sweep(input int sx, input int sy, input int sh,
                         input int extra_at, input int rst_at, input int clr_at);
        int   c0, mask, a, dead_exp;
        logic [23:0] col;
        ent_t e;
        c0   = cyc;
        mask = 0;
        for (int i = 0; i < NP; i++) begin
            a = model_addr(sx, sy, sh, i);
            e.cyc = c0 + 1 + i; e.a = i; e.b = a;
            aq.push_back(e);
            col = lookup(a);
            if ((haz_en[0] && col == haz_color0) || (haz_en[1] && col == haz_color1))
                mask |= (1 << i);
        end
        dead_exp = (model_dead != 0 || mask != 0) ? 1 : 0;
        e.cyc = c0 + NP + LAT + 1; e.a = mask; e.b = dead_exp;
        dq.push_back(e);
        b_from = c0 + 1;
        b_to   = c0 + NP + LAT + 1;
        x = 10'(sx); y = 10'(sy); height = 7'(sh);
        for (int t = 0; t < NP + LAT + 4; t++) begin
            start      = (t == 0 || t == extra_at);
            Reset      = (rst_at >= 0 && t == rst_at);
            clear_dead = (clr_at >= 0 && (t == clr_at || t == clr_at + 1));
            if (rst_at >= 0 && t == rst_at) begin
                aq.delete();
                dq.delete();
                b_to = c0 + t;
            end
            if (rst_at >= 0 && t == rst_at + 1) begin
                check_val("rst_busy", 32'(busy), 0);
                check_val("rst_done", 32'(done), 0);
                check_val("rst_hit_mask", 32'(hit_mask), 0);
                check_val("rst_is_dead", 32'(is_dead), 0);
                check_val("rst_rom_addr", 32'(rom_addr), 0);
            end
            if (clr_at >= 0 && t == clr_at + 1)
                check_val("dead_set_wins", 32'(is_dead), 1);
            if (clr_at >= 0 && t == clr_at + 2) begin
                check_val("dead_cleared", 32'(is_dead), 0);
                check_val("mask_kept", 32'(hit_mask), mask);
            end
            @(posedge Clk); #1;
        end
        start = 1'b0; Reset = 1'b0; clear_dead = 1'b0;
        if (dq.size() != 0) begin
            check_val("done_missing", dq.size(), 0);
            dq.delete();
            aq.delete();
        end
        model_dead = (rst_at >= 0 || clr_at >= 0) ? 0 : dead_exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p, rx, ry, rh;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_val("reset_busy", 32'(busy), 0);
        check_val("reset_done", 32'(done), 0);
        check_val("reset_hit_mask", 32'(hit_mask), 0);
        check_val("reset_is_dead", 32'(is_dead), 0);
        check_val("reset_rom_addr", 32'(rom_addr), 0);
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Red cell under the right probe, green cell under the bottom probe.
        hot_a0 = model_addr(100, 200, 20, 2); hot_c0 = 24'hac0404;
        hot_a1 = model_addr(100, 200, 20, 0); hot_c1 = 24'h69a42a;
        haz_color0 = 24'hac0404;
        haz_color1 = 24'h69a42a;

        haz_en = 2'b00; sweep(100, 200, 20, -1, -1, -1);   // hazards disabled
        haz_en = 2'b10; sweep(100, 200, 20, -1, -1, -1);   // green at probe 0
        haz_en = 2'b01; sweep(100, 200, 20, -1, -1, -1);   // red at probe 2
        haz_en = 2'b11; sweep(100, 200, 20, -1, -1, NP + LAT + 1);  // clear coincides with done

        // Bottom-left corner clamping.
        sweep(3, 470, 40, -1, -1, -1);

        // Random geometry including off-screen coordinates, one hot cell on a random probe.
        for (int r = 0; r < 6; r++) begin
            rx = $urandom_range(0, 1023);
            ry = $urandom_range(0, 1023);
            rh = $urandom_range(0, 127);
            p  = $urandom_range(0, NP - 1);
            hot_a0     = model_addr(rx, ry, rh, p);
            hot_c0     = 24'($urandom()) | 24'h000001;
            haz_color0 = hot_c0;
            haz_en     = 2'($urandom_range(0, 3));
            sweep(rx, ry, rh, -1, -1, -1);
        end

        // Start while busy is dropped; then reset mid-sweep.
        hot_a0 = model_addr(100, 200, 20, 2); hot_c0 = 24'hac0404;
        haz_color0 = 24'hac0404;
        haz_en = 2'b01;
        sweep(100, 200, 20, 2, -1, -1);
        sweep(100, 200, 20, -1, 3, -1);
        repeat (10) @(posedge Clk);
        #1;
        check_val("post_reset_is_dead", 32'(is_dead), 0);
        check_val("post_reset_hit_mask", 32'(hit_mask), 0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
